// File: rtl/bn_layer4_pipe.sv
// Per-channel batch-norm ahead of the layer-4 RPReLU: out = sat((x*scale)>>>FRAC_BITS + bias).
// Two-stage pipeline, no back-pressure; scale/bias loaded serially under a small FSM.
module bn_layer4_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 128,
  parameter int FRAC_BITS   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode_in,
  input  logic                              data_in_valid,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_in,
  input  logic                              para_load_start,
  input  logic                              para_valid,
  input  logic [PARA_WIDTH-1:0]             para_data,
  output logic                              params_loaded,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_out,
  output logic                              data_out_valid
);

  localparam int PROD_W = DATA_WIDTH + PARA_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int CNT_W  = $clog2(2 * CHANNEL_NUM);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2 * CHANNEL_NUM - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    loaded_q, loaded_d;
  logic                    load_en, last_word, accept, start_load;

  logic signed [PARA_WIDTH-1:0] scale_q [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0] bias_q  [CHANNEL_NUM];
  logic signed [PROD_W-1:0]     prod_q  [CHANNEL_NUM];
  logic [DATA_WIDTH-1:0]        sat     [CHANNEL_NUM];
  logic                         vld1_q, vld2_q;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (para_load_start) state_d = LOAD;
      LOAD:    if (last_word)       state_d = RUN;
      RUN:     if (para_load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // A start pulse during LOAD is ignored, so the counter only restarts from IDLE/RUN.
  always_comb begin
    start_load = para_load_start && (state_q == IDLE || state_q == RUN);
    load_en    = (state_q == LOAD) && para_valid;
    last_word  = load_en && (cnt_q == LAST_WORD);
    accept     = (state_q == RUN) && mode_in && data_in_valid;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    if (start_load) begin
      cnt_d    = '0;
      loaded_d = 1'b0;
    end else if (load_en) begin
      cnt_d    = last_word ? '0 : cnt_q + 1'b1;
      loaded_d = loaded_q | last_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        scale_q[k] <= '0;
        bias_q[k]  <= '0;
      end
    end else if (load_en) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        if (cnt_q == CNT_W'(k))               scale_q[k] <= para_data;
        if (cnt_q == CNT_W'(k + CHANNEL_NUM)) bias_q[k]  <= para_data;
      end
    end
  end

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    logic signed [PROD_W-1:0] shifted;
    logic signed [SUM_W-1:0]  sum;
    assign shifted = prod_q[c] >>> FRAC_BITS;
    assign sum     = {shifted[PROD_W-1], shifted}
                   + {{(SUM_W-PARA_WIDTH){bias_q[c][PARA_WIDTH-1]}}, bias_q[c]};
    assign sat[c]  = (sum > SUM_MAX) ? OUT_MAX :
                     (sum < SUM_MIN) ? OUT_MIN : sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      data_out_q <= '0;
      for (int c = 0; c < CHANNEL_NUM; c++) prod_q[c] <= '0;
    end else begin
      vld1_q <= accept;
      vld2_q <= vld1_q;
      if (accept) begin
        for (int c = 0; c < CHANNEL_NUM; c++)
          prod_q[c] <= $signed(data_in[c*DATA_WIDTH +: DATA_WIDTH]) * scale_q[c];
      end
      if (vld1_q) begin
        for (int c = 0; c < CHANNEL_NUM; c++)
          data_out_q[c*DATA_WIDTH +: DATA_WIDTH] <= sat[c];
      end
    end
  end

  assign params_loaded  = loaded_q;
  assign data_out       = data_out_q;
  assign data_out_valid = vld2_q;

endmodule

// File: tb/tb_bn_layer4_pipe.sv
// Bench for bn_layer4_pipe: directed table of arithmetic corners plus randomized traffic
// scored against a cycle-level reference of load/accept behaviour.
module tb_bn_layer4_pipe;

  localparam int DW = 16;
  localparam int PW = 16;
  localparam int CH = 128;
  localparam int FB = 8;
  localparam int NW = 2 * CH;

  logic clk = 1'b0;
  logic rst, mode_in, data_in_valid, para_load_start, para_valid;
  logic [PW-1:0] para_data;
  logic [DW*CH-1:0] data_in, data_out;
  logic params_loaded, data_out_valid;

  always #5 clk = ~clk;

  bn_layer4_pipe #(.DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CH), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .data_in_valid(data_in_valid), .data_in(data_in),
    .para_load_start(para_load_start), .para_valid(para_valid), .para_data(para_data),
    .params_loaded(params_loaded), .data_out(data_out), .data_out_valid(data_out_valid)
  );

  typedef struct {int sc; int bs; int x; int exp;} vec_t;
  vec_t tbl[7];

  int n_cmp = 0, n_fail = 0;
  int x_v[CH], sc_m[CH], bs_m[CH], new_sc[CH], new_bs[CH];
  int s1_dat[CH], out_dat[CH];
  bit s1_vld, out_vld, run_m, loading_m, loaded_m;
  int idx_m;

  // Reference: exact product, floor division by 2^FB, add bias, clamp to the output range.
  function automatic int ref_bn(int x, int s, int b);
    longint p, q;
    p = longint'(x) * longint'(s);
    q = p / (longint'(1) << FB);
    if (p < 0 && (p % (longint'(1) << FB)) != 0) q = q - 1;
    q = q + b;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_vec();
    for (int c = 0; c < CH; c++) data_in[c*DW +: DW] = x_v[c][DW-1:0];
  endtask

  task automatic rand_vec();
    logic [15:0] r;
    for (int c = 0; c < CH; c++) begin
      r = 16'($urandom);
      x_v[c] = int'($signed(r));
    end
    drive_vec();
  endtask

  task automatic rand_params();
    logic [15:0] r;
    for (int c = 0; c < CH; c++) begin
      r = 16'($urandom); new_sc[c] = int'($signed(r));
      r = 16'($urandom); new_bs[c] = int'($signed(r));
    end
  endtask

  task automatic check_outs(input string tag);
    int bad, got;
    bad = -1;
    got = 0;
    chk({tag, " params_loaded"}, longint'(params_loaded), longint'(loaded_m));
    chk({tag, " data_out_valid"}, longint'(data_out_valid), longint'(out_vld));
    for (int c = 0; c < CH; c++)
      if (bad < 0 && int'($signed(data_out[c*DW +: DW])) != out_dat[c]) begin
        bad = c;
        got = int'($signed(data_out[c*DW +: DW]));
      end
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s data_out ch%0d: got %0d expected %0d", tag, bad, got, out_dat[bad]);
    end
  endtask

  // One clock: the model decides acceptance from pre-edge inputs, then applies load effects.
  task automatic cycle();
    bit acc;
    int nxt[CH];
    acc = run_m && mode_in && data_in_valid;
    for (int c = 0; c < CH; c++) nxt[c] = acc ? ref_bn(x_v[c], sc_m[c], bs_m[c]) : 0;
    @(posedge clk); #1;
    out_vld = s1_vld;
    if (s1_vld) out_dat = s1_dat;
    s1_vld = acc;
    if (acc) s1_dat = nxt;
    if (loading_m) begin
      if (para_valid) begin
        if (idx_m < CH) sc_m[idx_m] = int'($signed(para_data));
        else            bs_m[idx_m-CH] = int'($signed(para_data));
        idx_m++;
        if (idx_m == NW) begin
          loading_m = 0; run_m = 1; loaded_m = 1;
        end
      end
    end else if (para_load_start) begin
      loading_m = 1; idx_m = 0; loaded_m = 0; run_m = 0;
    end
    check_outs("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin
      sc_m[c] = 0; bs_m[c] = 0; out_dat[c] = 0; s1_dat[c] = 0;
    end
    s1_vld = 0; out_vld = 0; run_m = 0; loading_m = 0; loaded_m = 0; idx_m = 0;
    check_outs("reset");
  endtask

  // Start pulse, then n words with random para_valid gaps; a stray start pulse lands mid-load.
  task automatic load_words(input int n);
    int g;
    para_load_start = 1'b1; para_valid = 1'b0;
    cycle();
    para_load_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      g = (k == 50) ? 1 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      for (int j = 0; j < g; j++) begin
        para_valid = 1'b0;
        para_load_start = (k == 50);
        mode_in = 1'b1;
        data_in_valid = ($urandom_range(0, 1) == 1);
        rand_vec();
        cycle();
        para_load_start = 1'b0;
      end
      para_valid = 1'b1;
      para_data = (k < CH) ? new_sc[k][15:0] : new_bs[k-CH][15:0];
      data_in_valid = ($urandom_range(0, 1) == 1);
      cycle();
      if (k == NW - 1) chk("loaded_after_last_word", longint'(params_loaded), 1);
    end
    para_valid = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic traffic(input int n);
    for (int i = 0; i < n; i++) begin
      mode_in = ($urandom_range(0, 7) != 0);
      data_in_valid = ($urandom_range(0, 5) != 0);
      rand_vec();
      cycle();
    end
    data_in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{sc: 256,  bs: 0,     x: 1234,   exp: 1234};
    tbl[1] = '{sc: 512,  bs: 0,     x: 20000,  exp: 32767};
    tbl[2] = '{sc: 512,  bs: 0,     x: -20000, exp: -32768};
    tbl[3] = '{sc: 256,  bs: 32767, x: 1,      exp: 32767};
    tbl[4] = '{sc: -128, bs: 0,     x: 3,      exp: -2};
    tbl[5] = '{sc: -128, bs: 0,     x: -3,     exp: 1};
    tbl[6] = '{sc: -128, bs: 10,    x: 3,      exp: 8};

    rst = 1'b1; mode_in = 1'b0; data_in_valid = 1'b0; para_load_start = 1'b0;
    para_valid = 1'b0; para_data = '0; data_in = '0;
    for (int c = 0; c < CH; c++) x_v[c] = 0;
    do_reset();

    // Vectors offered in IDLE must be dropped.
    mode_in = 1'b1; data_in_valid = 1'b1;
    repeat (3) begin rand_vec(); cycle(); end
    data_in_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < CH; c++) begin new_sc[c] = tbl[i].sc; new_bs[c] = tbl[i].bs; end
      load_words(NW);
      mode_in = 1'b1;
      for (int c = 0; c < CH; c++) x_v[c] = tbl[i].x;
      drive_vec();
      data_in_valid = 1'b1;
      cycle();
      data_in_valid = 1'b0;
      cycle();
      chk("tbl valid at accept+2", longint'(data_out_valid), 1);
      chk("tbl ch0", longint'($signed(data_out[DW-1:0])), tbl[i].exp);
      chk("tbl chlast", longint'($signed(data_out[DW*CH-1 -: DW])), tbl[i].exp);
      cycle();
      chk("tbl valid pulse ends", longint'(data_out_valid), 0);
    end

    // Random parameters, mode_in=0 gating, then mixed back-to-back traffic.
    rand_params();
    load_words(NW);
    mode_in = 1'b0; data_in_valid = 1'b1;
    repeat (4) begin rand_vec(); cycle(); end
    mode_in = 1'b1;
    repeat (4) begin rand_vec(); cycle(); end
    traffic(60);

    // Reset in the middle of a load, then a clean load.
    rand_params();
    load_words(100);
    do_reset();
    rand_params();
    load_words(NW);
    traffic(20);

    // Two vectors in flight when a reload starts: both must use the old parameters.
    mode_in = 1'b1; data_in_valid = 1'b1;
    rand_vec(); cycle();
    rand_vec(); cycle();
    data_in_valid = 1'b0;
    rand_params();
    load_words(NW);
    traffic(20);
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
